// File: rtl/bowling_pkg.sv
// Shared types for the bowling lane controller and scorer.
// State encoding, pin/roll counter types and game limits.
package bowling_pkg;

    localparam int MAX_PINS  = 10;
    localparam int MAX_ROLLS = 21;

    typedef logic [3:0] pin_t;
    typedef logic [4:0] roll_cnt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RACK,
        S_WAIT_BALL,
        S_SETUP,
        S_STRIKE,
        S_CLEAR,
        S_SCORE,
        S_DONE
    } state_e;

endpackage

// File: rtl/bowling_frame_tracker.sv
// Frame/ball bookkeeping, including all tenth-frame bonus rules.
// Decisions are registered on the roll strobe and read back in CLEAR.
module bowling_frame_tracker
    import bowling_pkg::*;
#(
    parameter int FRAMES = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       new_game_i,
    input  logic       roll_i,
    input  pin_t       knocked_i,
    output logic [3:0] frame_o,
    output logic [1:0] ball_o,
    output logic       need_rack_o,
    output logic       game_end_o
);

    logic [3:0] frame_q, frame_d;
    logic [1:0] ball_q, ball_d;
    pin_t       first_q, first_d;
    logic       need_rack_q, need_rack_d;
    logic       game_end_q, game_end_d;
    logic       strike, spare, last_frame;

    assign strike     = (knocked_i == pin_t'(MAX_PINS));
    assign spare      = ({1'b0, first_q} + {1'b0, knocked_i}) == 5'(MAX_PINS);
    assign last_frame = (frame_q >= 4'(FRAMES));

    always_comb begin
        frame_d     = frame_q;
        ball_d      = ball_q;
        first_d     = first_q;
        need_rack_d = need_rack_q;
        game_end_d  = game_end_q;
        if (new_game_i) begin
            frame_d     = 4'd1;
            ball_d      = 2'd1;
            first_d     = '0;
            need_rack_d = 1'b0;
            game_end_d  = 1'b0;
        end else if (roll_i) begin
            need_rack_d = 1'b0;
            if (!last_frame) begin
                if (ball_q == 2'd1 && !strike) begin
                    ball_d  = 2'd2;
                    first_d = knocked_i;
                end else begin
                    frame_d     = frame_q + 4'd1;
                    ball_d      = 2'd1;
                    need_rack_d = 1'b1;
                end
            end else if (ball_q == 2'd1) begin
                first_d     = knocked_i;
                ball_d      = 2'd2;
                need_rack_d = strike;
            end else if (ball_q == 2'd2 && first_q == pin_t'(MAX_PINS)) begin
                // After a first-ball strike, only a second strike re-racks.
                ball_d      = 2'd3;
                need_rack_d = strike;
            end else if (ball_q == 2'd2 && spare) begin
                ball_d      = 2'd3;
                need_rack_d = 1'b1;
            end else begin
                game_end_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            frame_q     <= '0;
            ball_q      <= '0;
            first_q     <= '0;
            need_rack_q <= 1'b0;
            game_end_q  <= 1'b0;
        end else begin
            frame_q     <= frame_d;
            ball_q      <= ball_d;
            first_q     <= first_d;
            need_rack_q <= need_rack_d;
            game_end_q  <= game_end_d;
        end
    end

    assign frame_o     = frame_q;
    assign ball_o      = ball_q;
    assign need_rack_o = need_rack_q;
    assign game_end_o  = game_end_q;

endmodule

// File: rtl/bowling_lane_controller.sv
// Lane-side roll transmitter: sensor readings in, scorer roll protocol out.
// Sequences racks, validates readings and holds calculate_score at game end.
module bowling_lane_controller
    import bowling_pkg::*;
#(
    parameter int SCORE_CYCLES = 10,
    parameter int FRAMES       = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       ball_valid,
    input  logic [3:0] pins_standing,
    output logic       ball_ready,
    output logic       rack_req,
    input  logic       rack_ack,
    output logic       roll,
    output logic [3:0] pin_count,
    output logic       calculate_score,
    output logic [3:0] frame,
    output logic [1:0] ball,
    output logic [4:0] roll_total,
    output logic       game_over,
    output logic       sensor_error
);

    localparam int CW = $clog2(SCORE_CYCLES + 1);

    state_e        state_q, state_d;
    pin_t          standing_q, standing_d;
    pin_t          knocked_q, knocked_d;
    roll_cnt_t     total_q, total_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          new_game, bad_read, need_rack, game_end;

    assign new_game = start && (state_q == S_IDLE || state_q == S_DONE);
    assign bad_read = (pins_standing > standing_q)
                   || (pins_standing > pin_t'(MAX_PINS));

    always_comb begin
        state_d    = state_q;
        standing_d = standing_q;
        knocked_d  = knocked_q;
        total_d    = total_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RACK;
                    total_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_RACK: begin
                if (rack_ack) begin
                    standing_d = pin_t'(MAX_PINS);
                    state_d    = S_WAIT_BALL;
                end
            end
            S_WAIT_BALL: begin
                // An impossible reading is dropped; only the flag records it.
                if (ball_valid && bad_read) begin
                    err_d = 1'b1;
                end else if (ball_valid) begin
                    knocked_d  = standing_q - pins_standing;
                    standing_d = pins_standing;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: state_d = S_STRIKE;
            S_STRIKE: begin
                total_d = total_q + 5'd1;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (game_end) begin
                    state_d = S_SCORE;
                    cnt_d   = '0;
                end else if (need_rack) begin
                    state_d = S_RACK;
                end else begin
                    state_d = S_WAIT_BALL;
                end
            end
            S_SCORE: begin
                if (cnt_q == CW'(SCORE_CYCLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            standing_q <= '0;
            knocked_q  <= '0;
            total_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            standing_q <= standing_d;
            knocked_q  <= knocked_d;
            total_q    <= total_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    bowling_frame_tracker #(
        .FRAMES(FRAMES)
    ) u_tracker (
        .clock      (clock),
        .reset_n    (reset_n),
        .new_game_i (new_game),
        .roll_i     (state_q == S_STRIKE),
        .knocked_i  (knocked_q),
        .frame_o    (frame),
        .ball_o     (ball),
        .need_rack_o(need_rack),
        .game_end_o (game_end)
    );

    assign ball_ready      = (state_q == S_WAIT_BALL);
    assign rack_req        = (state_q == S_RACK);
    assign roll            = (state_q == S_STRIKE);
    assign pin_count       = (state_q == S_SETUP || state_q == S_STRIKE)
                           ? knocked_q : '0;
    assign calculate_score = (state_q == S_SCORE);
    assign roll_total      = total_q;
    assign game_over       = game_end;
    assign sensor_error    = err_q;

endmodule

// File: tb/tb_bowling_lane_controller.sv
// Bench for bowling_lane_controller: game table plus roll scoreboard.
module tb_bowling_lane_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       ball_valid = 1'b0;
    logic [3:0] pins_standing = '0;
    logic       rack_ack = 1'b0;
    logic       ball_ready, rack_req, roll, calculate_score;
    logic       game_over, sensor_error;
    logic [3:0] pin_count, frame;
    logic [1:0] ball;
    logic [4:0] roll_total;

    bowling_lane_controller #(
        .SCORE_CYCLES(10),
        .FRAMES      (10)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .ball_valid     (ball_valid),
        .pins_standing  (pins_standing),
        .ball_ready     (ball_ready),
        .rack_req       (rack_req),
        .rack_ack       (rack_ack),
        .roll           (roll),
        .pin_count      (pin_count),
        .calculate_score(calculate_score),
        .frame          (frame),
        .ball           (ball),
        .roll_total     (roll_total),
        .game_over      (game_over),
        .sensor_error   (sensor_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  n;
        logic [4:0]  total;
        logic [4:0]  nrack;
        logic [83:0] rd;
        logic [83:0] pc;
    } game_t;

    game_t tbl[6];
    int    exp_q[$];
    int    checks = 0;
    int    passed = 0;
    int    rolls = 0;
    int    racks = 0;
    int    prev_pc = 0;
    bit    prev_rack = 1'b0;

    task automatic check(input string nm, input int act, input int want);
        checks++;
        if (act == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, want);
    endtask

    always @(negedge clock) begin
        if (roll) begin
            rolls++;
            check("pin_setup", int'(pin_count), prev_pc);
            if (exp_q.size() == 0) check("unexpected_roll", 1, 0);
            else check("pin_count", int'(pin_count), exp_q.pop_front());
        end
        if (rack_req && !prev_rack) racks++;
        prev_pc   = int'(pin_count);
        prev_rack = rack_req;
    end

    task automatic set_b(input int g, input int i, input int r, input int p);
        tbl[g].rd[4*i +: 4] = 4'(r);
        tbl[g].pc[4*i +: 4] = 4'(p);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int b = 50;
        while (!ball_ready && b > 0) begin
            if (rack_req) begin
                rack_ack = 1'b1;
                @(negedge clock);
                rack_ack = 1'b0;
            end else begin
                @(negedge clock);
            end
            b--;
        end
        if (!ball_ready) check("timeout_ready", 0, 1);
    endtask

    task automatic drive_ball(input int rd, input int pc, input bit push);
        if (push) exp_q.push_back(pc);
        ball_valid    = 1'b1;
        pins_standing = 4'(rd);
        @(negedge clock);
        ball_valid = 1'b0;
    endtask

    task automatic play(input int g);
        int b;
        int cnt;
        int n;
        n     = int'(tbl[g].n);
        rolls = 0;
        racks = 0;
        do_start();
        for (int i = 0; i < n; i++) begin
            wait_ready();
            if (i == n - 1) check($sformatf("g%0d_early_over", g), game_over, 0);
            drive_ball(int'(tbl[g].rd[4*i +: 4]), int'(tbl[g].pc[4*i +: 4]), 1'b1);
        end
        b = 100;
        while (!calculate_score && b > 0) begin
            @(negedge clock);
            b--;
        end
        if (!calculate_score) check($sformatf("g%0d_timeout_score", g), 0, 1);
        check($sformatf("g%0d_game_over", g), game_over, 1);
        cnt = 0;
        while (calculate_score && cnt < 100) begin
            cnt++;
            @(negedge clock);
        end
        check($sformatf("g%0d_score_cycles", g), cnt, 10);
        check($sformatf("g%0d_roll_total", g), roll_total, int'(tbl[g].total));
        check($sformatf("g%0d_rolls", g), rolls, n);
        check($sformatf("g%0d_racks", g), racks, int'(tbl[g].nrack));
        check($sformatf("g%0d_frame", g), frame, 10);
        check($sformatf("g%0d_sb_empty", g), exp_q.size(), 0);
    endtask

    initial begin
        int r0;
        for (int g = 0; g < 6; g++) tbl[g] = '0;
        tbl[0].n = 20; tbl[0].total = 20; tbl[0].nrack = 10;
        for (int i = 0; i < 20; i++) set_b(0, i, 10, 0);
        tbl[1].n = 19; tbl[1].total = 19; tbl[1].nrack = 10;
        set_b(1, 0, 0, 10); set_b(1, 1, 7, 3); set_b(1, 2, 3, 4);
        for (int i = 3; i < 19; i++) set_b(1, i, 10, 0);
        tbl[2].n = 12; tbl[2].total = 12; tbl[2].nrack = 12;
        for (int i = 0; i < 12; i++) set_b(2, i, 0, 10);
        tbl[3].n = 21; tbl[3].total = 21; tbl[3].nrack = 11;
        for (int i = 0; i < 18; i++) set_b(3, i, 10, 0);
        set_b(3, 18, 4, 6); set_b(3, 19, 0, 4); set_b(3, 20, 5, 5);
        tbl[4].n = 20; tbl[4].total = 20; tbl[4].nrack = 10;
        for (int i = 0; i < 18; i++) set_b(4, i, 10, 0);
        set_b(4, 18, 7, 3); set_b(4, 19, 3, 4);
        tbl[5].n = 21; tbl[5].total = 21; tbl[5].nrack = 11;
        for (int i = 0; i < 18; i++) set_b(5, i, 10, 0);
        set_b(5, 18, 0, 10); set_b(5, 19, 6, 4); set_b(5, 20, 2, 4);

        repeat (3) @(negedge clock);
        check("reset_outputs", int'({ball_ready, rack_req, roll, pin_count,
              calculate_score, frame, ball, roll_total, game_over,
              sensor_error}), 0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int g = 0; g < 6; g++) play(g);

        // Sensor error and roll timing, starting from DONE.
        do_start();
        check("rack_after_start", rack_req, 1);
        ball_valid = 1'b1;
        @(negedge clock);
        ball_valid = 1'b0;
        check("ball_ignored_in_rack", rack_req, 1);
        rack_ack = 1'b1;
        @(negedge clock);
        rack_ack = 1'b0;
        check("ack_ready", {rack_req, ball_ready}, 1);
        drive_ball(7, 3, 1'b1);
        check("t1_pin_count", pin_count, 3);
        check("t1_no_roll", {roll, ball_ready}, 0);
        @(negedge clock);
        check("t2_roll", roll, 1);
        @(negedge clock);
        check("t3_clear", {roll, pin_count}, 0);
        @(negedge clock);
        check("t4_ready", ball_ready, 1);
        check("err_clear", sensor_error, 0);
        r0 = rolls;
        drive_ball(9, 0, 1'b0);
        check("err_set", sensor_error, 1);
        check("err_ready", ball_ready, 1);
        repeat (3) @(negedge clock);
        check("err_no_roll", rolls, r0);
        drive_ball(5, 2, 1'b1);
        repeat (3) @(negedge clock);
        check("after_err_roll", rolls, r0 + 1);
        check("err_sticky", sensor_error, 1);
        check("frame2", frame, 2);
        do_start();
        check("start_ignored", {sensor_error, roll_total}, {1'b1, 5'd2});

        // Reset in SETUP abandons the roll.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_start();
        wait_ready();
        drive_ball(4, 0, 1'b0);
        check("setup_pc", pin_count, 6);
        reset_n = 1'b0;
        @(negedge clock);
        check("midroll_reset", int'({ball_ready, rack_req, roll, pin_count,
              calculate_score, frame, ball, roll_total, game_over,
              sensor_error}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        do_start();
        wait_ready();
        drive_ball(3, 7, 1'b1);
        repeat (3) @(negedge clock);
        check("replay_total", roll_total, 1);
        check("replay_frame_ball", {frame, ball}, {4'd1, 2'd2});
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
